// File: rtl/axis_packet_serializer_if.sv
// AXI4-Stream master-side bundle for axis_packet_serializer.
// Data lane 0 sits in the TDATA LSBs.
interface axis_packet_serializer_if #(
    parameter int unsigned CHAR_W = 8,
    parameter int unsigned LANES  = 4
);
    logic [LANES*CHAR_W-1:0] TDATA;
    logic [LANES-1:0]        TKEEP;
    logic                    TLAST;
    logic                    TVALID;
    logic                    TREADY;

    modport master (output TDATA, output TKEEP, output TLAST, output TVALID, input TREADY);
    modport slave  (input TDATA, input TKEEP, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/axis_packet_serializer.sv
// Snapshots an N-character vector and streams it as LANES-wide AXI4-Stream beats via a FWFT FIFO.
// Optional macro AXIS_SERIALIZER_DRAIN_WAIT_EN delays 'valid' until the FIFO has fully drained.
module axis_packet_serializer #(
    parameter int unsigned CHAR_W    = 8,
    parameter int unsigned N         = 10,
    parameter int unsigned LANES     = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    axis_packet_serializer_if.master M_AXIS,
    input  logic                     run,
    input  logic [N*CHAR_W-1:0]      d,
    output logic                     valid,
    output logic                     busy
);
    localparam int unsigned BEATS   = (N + LANES - 1) / LANES;
    localparam int unsigned IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned DATA_W  = LANES * CHAR_W;
    localparam int unsigned ENTRY_W = 1 + LANES + DATA_W;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N*CHAR_W-1:0]  snap_q;
    logic                 snap_en;

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic                 full, empty, push, pop;
    logic [ENTRY_W-1:0]   head;

    logic [DATA_W-1:0]    beat_data;
    logic [LANES-1:0]     beat_keep;
    logic                 beat_last;

    // Lanes past the last character are zero-filled with TKEEP cleared.
    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (32'(idx_q) * LANES + j < N) begin
                beat_data[j*CHAR_W +: CHAR_W] = snap_q[(32'(idx_q) * LANES + j) * CHAR_W +: CHAR_W];
                beat_keep[j] = 1'b1;
            end
        end
    end

    assign beat_last = (32'(idx_q) == BEATS - 1);

    assign full  = (count_q == (LOG_DEPTH + 1)'(DEPTH));
    assign empty = (count_q == '0);
    // run gates the write so the abort edge never queues an extra beat.
    assign push  = (state_q == StLoad) && run && !full;
    assign pop   = !empty && M_AXIS.TREADY;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    snap_en = 1'b1;
                end
            end
            StLoad: begin
                if (!run) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else if (!full) begin
                    if (beat_last) state_d = StDone;
                    else           idx_d   = idx_q + IDX_W'(1);
                end
            end
            StDone: begin
                if (!run) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + (LOG_DEPTH + 1)'(1);
        else if (!push && pop) count_d = count_q - (LOG_DEPTH + 1)'(1);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            snap_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            if (snap_en) snap_q   <= d;
            if (push)    wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= {beat_last, beat_keep, beat_data};
    end

    assign head          = empty ? '0 : mem_q[rd_ptr_q];
    assign M_AXIS.TLAST  = head[ENTRY_W-1];
    assign M_AXIS.TKEEP  = head[DATA_W +: LANES];
    assign M_AXIS.TDATA  = head[DATA_W-1:0];
    assign M_AXIS.TVALID = !empty;

    assign busy = (state_q == StLoad);
`ifdef AXIS_SERIALIZER_DRAIN_WAIT_EN
    assign valid = (state_q == StDone) && empty;
`else
    assign valid = (state_q == StDone);
`endif
endmodule

// File: tb/tb_axis_packet_serializer.sv
// Directed bench: three serializers (default, DEPTH=2, LANES=5) share one stimulus stream.
module tb_axis_packet_serializer;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned N      = 10;
`ifdef AXIS_SERIALIZER_DRAIN_WAIT_EN
    localparam bit DrainWait = 1'b1;
`else
    localparam bit DrainWait = 1'b0;
`endif

    logic                ACLK    = 1'b0;
    logic                ARESETN = 1'b0;
    logic                run     = 1'b0;
    logic                tready  = 1'b0;
    logic [N*CHAR_W-1:0] d       = '0;
    logic                valid_a, busy_a, valid_b, busy_b, valid_c, busy_c;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cap_data [4];
    logic [3:0]  cap_keep [4];
    logic        cap_last [4];
    int          cap_n;

    axis_packet_serializer_if #(.CHAR_W(8), .LANES(4)) axis_a ();
    axis_packet_serializer_if #(.CHAR_W(8), .LANES(4)) axis_b ();
    axis_packet_serializer_if #(.CHAR_W(8), .LANES(5)) axis_c ();

    assign axis_a.TREADY = tready;
    assign axis_b.TREADY = tready;
    assign axis_c.TREADY = tready;

    always #5 ACLK = ~ACLK;

    axis_packet_serializer #(.CHAR_W(8), .N(10), .LANES(4), .DEPTH(16), .LOG_DEPTH(4)) dut_a (
        .ACLK(ACLK), .ARESETN(ARESETN), .M_AXIS(axis_a), .run(run), .d(d),
        .valid(valid_a), .busy(busy_a)
    );
    axis_packet_serializer #(.CHAR_W(8), .N(10), .LANES(4), .DEPTH(2), .LOG_DEPTH(1)) dut_b (
        .ACLK(ACLK), .ARESETN(ARESETN), .M_AXIS(axis_b), .run(run), .d(d),
        .valid(valid_b), .busy(busy_b)
    );
    axis_packet_serializer #(.CHAR_W(8), .N(10), .LANES(5), .DEPTH(4), .LOG_DEPTH(2)) dut_c (
        .ACLK(ACLK), .ARESETN(ARESETN), .M_AXIS(axis_c), .run(run), .d(d),
        .valid(valid_c), .busy(busy_c)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Characters base+1 .. base+N.
    task automatic load_chars(input logic [7:0] base);
        for (int i = 0; i < int'(N); i++) d[i*CHAR_W +: CHAR_W] = base + 8'(i + 1);
    endtask

    // Records each head beat while TREADY=1 until TLAST is seen; bounded.
    task automatic collect(input bit use_b);
        logic        v, l;
        logic [31:0] dt;
        logic [3:0]  k;
        cap_n = 0;
        for (int i = 0; i < 20; i++) begin
            v  = use_b ? axis_b.TVALID : axis_a.TVALID;
            l  = use_b ? axis_b.TLAST  : axis_a.TLAST;
            dt = use_b ? axis_b.TDATA  : axis_a.TDATA;
            k  = use_b ? axis_b.TKEEP  : axis_a.TKEEP;
            if (v && cap_n < 4) begin
                cap_data[cap_n] = dt;
                cap_keep[cap_n] = k;
                cap_last[cap_n] = l;
                cap_n++;
            end
            if (v && l) break;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  hs_k, first_v;
        bit  hs_pending;
        bit  stable;

        // Reset state
        tick();
        tick();
        check_eq("rst_tvalid", 64'(axis_a.TVALID), 64'd0);
        check_eq("rst_tdata",  64'(axis_a.TDATA),  64'd0);
        check_eq("rst_tkeep",  64'(axis_a.TKEEP),  64'd0);
        check_eq("rst_tlast",  64'(axis_a.TLAST),  64'd0);
        check_eq("rst_valid",  64'(valid_a),       64'd0);
        check_eq("rst_busy",   64'(busy_a),        64'd0);
        ARESETN = 1'b1;
        tick();

        // Basic pack (dut_a) and exact fit (dut_c), TREADY=1
        tready = 1'b1;
        load_chars(8'h00);
        run = 1'b1;
        tick();
        check_eq("basic_busy",    64'(busy_a),        64'd1);
        check_eq("basic_tv_t0",   64'(axis_a.TVALID), 64'd0);
        tick();
        check_eq("basic_tv_t1",   64'(axis_a.TVALID), 64'd1);
        check_eq("basic_b0_data", 64'(axis_a.TDATA),  64'h04030201);
        check_eq("basic_b0_keep", 64'(axis_a.TKEEP),  64'hF);
        check_eq("basic_b0_last", 64'(axis_a.TLAST),  64'd0);
        check_eq("fit_b0_data",   64'(axis_c.TDATA),  64'h0504030201);
        check_eq("fit_b0_keep",   64'(axis_c.TKEEP),  64'h1F);
        check_eq("fit_b0_last",   64'(axis_c.TLAST),  64'd0);
        tick();
        check_eq("basic_b1_data", 64'(axis_a.TDATA),  64'h08070605);
        check_eq("basic_b1_keep", 64'(axis_a.TKEEP),  64'hF);
        check_eq("basic_b1_last", 64'(axis_a.TLAST),  64'd0);
        check_eq("fit_b1_data",   64'(axis_c.TDATA),  64'h0A09080706);
        check_eq("fit_b1_keep",   64'(axis_c.TKEEP),  64'h1F);
        check_eq("fit_b1_last",   64'(axis_c.TLAST),  64'd1);
        check_eq("fit_valid_t2",  64'(valid_c),       64'(!DrainWait));
        tick();
        check_eq("basic_b2_data", 64'(axis_a.TDATA),  64'h00000A09);
        check_eq("basic_b2_keep", 64'(axis_a.TKEEP),  64'h3);
        check_eq("basic_b2_last", 64'(axis_a.TLAST),  64'd1);
        check_eq("basic_valid_t3", 64'(valid_a),      64'(!DrainWait));
        check_eq("fit_tv_t3",     64'(axis_c.TVALID), 64'd0);
        check_eq("fit_valid_t3",  64'(valid_c),       64'd1);
        tick();
        check_eq("basic_tv_t4",   64'(axis_a.TVALID), 64'd0);
        check_eq("basic_valid_t4", 64'(valid_a),      64'd1);
        check_eq("basic_busy_t4", 64'(busy_a),        64'd0);
        run = 1'b0;
        tick();
        check_eq("basic_valid_idle", 64'(valid_a),    64'd0);

        // Backpressure on dut_b (DEPTH=2)
        tready = 1'b0;
        load_chars(8'h10);
        run = 1'b1;
        tick();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (axis_b.TVALID !== 1'b1 || axis_b.TDATA !== 32'h14131211 ||
                axis_b.TKEEP !== 4'hF || axis_b.TLAST !== 1'b0) stable = 1'b0;
        end
        check_eq("bp_head_stable", 64'(stable), 64'd1);
        check_eq("bp_busy",        64'(busy_b), 64'd1);
        check_eq("bp_valid_stall", 64'(valid_b), 64'd0);
        tready = 1'b1;
        collect(1'b1);
        check_eq("bp_n",       64'(cap_n),       64'd3);
        check_eq("bp_b0_data", 64'(cap_data[0]), 64'h14131211);
        check_eq("bp_b1_data", 64'(cap_data[1]), 64'h18171615);
        check_eq("bp_b2_data", 64'(cap_data[2]), 64'h00001A19);
        check_eq("bp_b2_keep", 64'(cap_keep[2]), 64'h3);
        check_eq("bp_b1_last", 64'(cap_last[1]), 64'd0);
        check_eq("bp_b2_last", 64'(cap_last[2]), 64'd1);
        tick();
        check_eq("bp_valid_end", 64'(valid_b), 64'd1);
        run = 1'b0;
        tick();
        tick();

        // Abort after the first write
        tready = 1'b0;
        load_chars(8'h20);
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        tick();
        check_eq("abort_busy",    64'(busy_a),        64'd0);
        check_eq("abort_tv",      64'(axis_a.TVALID), 64'd1);
        check_eq("abort_data",    64'(axis_a.TDATA),  64'h24232221);
        check_eq("abort_keep",    64'(axis_a.TKEEP),  64'hF);
        check_eq("abort_last",    64'(axis_a.TLAST),  64'd0);
        tready = 1'b1;
        tick();
        check_eq("abort_one_beat", 64'(axis_a.TVALID), 64'd0);
        tick();
        check_eq("abort_idle_valid", 64'(valid_a), 64'd0);
        load_chars(8'h30);
        run = 1'b1;
        tick();
        collect(1'b0);
        check_eq("rerun_n",       64'(cap_n),       64'd3);
        check_eq("rerun_b0_data", 64'(cap_data[0]), 64'h34333231);
        check_eq("rerun_b1_data", 64'(cap_data[1]), 64'h38373635);
        check_eq("rerun_b2_data", 64'(cap_data[2]), 64'h00003A39);
        check_eq("rerun_b2_keep", 64'(cap_keep[2]), 64'h3);
        check_eq("rerun_b2_last", 64'(cap_last[2]), 64'd1);
        tick();
        run = 1'b0;
        tick();

        // Reset mid-drain, with a between-edge pulse first
        tready = 1'b0;
        load_chars(8'h40);
        run = 1'b1;
        tick();
        tick();
        tick();
        ARESETN = 1'b0;
        #2;
        ARESETN = 1'b1;
        #1;
        check_eq("glitch_busy", 64'(busy_a),        64'd1);
        check_eq("glitch_tv",   64'(axis_a.TVALID), 64'd1);
        ARESETN = 1'b0;
        tick();
        check_eq("mrst_tvalid", 64'(axis_a.TVALID), 64'd0);
        check_eq("mrst_tdata",  64'(axis_a.TDATA),  64'd0);
        check_eq("mrst_tkeep",  64'(axis_a.TKEEP),  64'd0);
        check_eq("mrst_tlast",  64'(axis_a.TLAST),  64'd0);
        check_eq("mrst_valid",  64'(valid_a),       64'd0);
        check_eq("mrst_busy",   64'(busy_a),        64'd0);
        ARESETN = 1'b1;
        run = 1'b0;
        tick();

        // Toggling TREADY: TLAST handshake lands on edge t+7
        load_chars(8'h50);
        run = 1'b1;
        tick();
        hs_k    = -1;
        first_v = -1;
        for (int k = 1; k <= 12; k++) begin
            tready     = (k % 2 == 1);
            hs_pending = axis_a.TVALID && tready && axis_a.TLAST;
            tick();
            if (hs_pending && hs_k < 0) hs_k = k;
            if (valid_a && first_v < 0) first_v = k;
        end
        check_eq("drain_hs_edge",    64'(hs_k),    64'd7);
        check_eq("drain_valid_edge", 64'(first_v), DrainWait ? 64'd7 : 64'd3);
        run = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_packet_serializer.md
Name: axis_packet_serializer

Overview:
- Parametrised successor to the training-path AXI Stream output stage.
- Captures an N-character result vector and packs LANES characters per beat onto an AXI4-Stream master.
- Provides TKEEP for partial final beats and TLAST on the final beat, through an internal first-word-fall-through FIFO.
- Sits between the training core's result register and the DMA S2MM port.

Parameters:
- CHAR_W, 8: bits per character.
- N, 10: characters per packet.
- LANES, 4: characters per beat. BEATS = ceil(N/LANES).
- DEPTH, 16: FIFO entries in beats; power of 2, at least 2.
- LOG_DEPTH, 4: log2(DEPTH).

Ports:
- ACLK, in, 1: clock.
- ARESETN, in, 1: synchronous active-low reset.
- M_AXIS_TDATA, out, LANES*CHAR_W: beat data; lane 0 in the LSBs.
- M_AXIS_TKEEP, out, LANES: per-lane valid.
- M_AXIS_TLAST, out, 1: final beat of packet.
- M_AXIS_TVALID, out, 1: beat available.
- M_AXIS_TREADY, in, 1: downstream accept.
- run, in, 1: start/hold request.
- d, in, N*CHAR_W: packet; char i at d[i*CHAR_W +: CHAR_W].
- valid, out, 1: packet fully queued (see Optional Feature).
- busy, out, 1: state is LOAD.

Behaviour:
- Clock and reset:
  - One clock, ACLK.
  - ARESETN sampled on the ACLK rising edge only; synchronous, active-low.
  - Reset clears state to IDLE, beat index, FIFO pointers and count, and the snapshot register.
  - Outputs during and after reset: TVALID=0, TDATA=0, TKEEP=0, TLAST=0, valid=0, busy=0.
- Reset mid-operation: FIFO contents are discarded and TVALID drops to 0 the cycle after the reset edge. A partially sent packet is truncated; this is acceptable.
- State machine (IDLE, LOAD, DONE):
  - IDLE & run: snapshot d into an internal register, beat index=0, go to LOAD. d is don't-care after this edge.
  - LOAD: each edge with FIFO not full writes beat[index] and increments index. The edge that writes beat BEATS-1 goes to DONE. A full FIFO stalls with no write and index held.
  - LOAD & ~run: abort and go to IDLE, index=0. Beats already written stay queued and drain normally; no TLAST is fabricated.
  - DONE & run: stay in DONE. DONE & ~run: go to IDLE.
  - A new packet needs run to go low for at least one cycle, then high again.
- Packing, beat b, lane j:
  - Lane j carries char b*LANES+j.
  - If b*LANES+j >= N, the lane data is 0 and TKEEP[j]=0; otherwise TKEEP[j]=1.
  - TLAST=1 only on beat BEATS-1.
  - The FIFO entry is {TLAST, TKEEP, TDATA}.
- FIFO:
  - FWFT. TVALID = ~empty. TDATA/TKEEP/TLAST show the head entry and are forced to 0 when empty.
  - A pop occurs when TVALID & TREADY.
  - Occupancy counter is LOG_DEPTH+1 bits wide; pointers wrap modulo DEPTH.
  - Write enable uses full as of cycle start. A simultaneous pop does not free space in that same cycle.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - A pop never occurs when empty.
- Latency: run sampled high in IDLE at edge t gives first write at edge t+1 and TVALID=1 after t+1. With TREADY=1 and no stall, valid=1 after edge t+BEATS.
- AXI rule: once TVALID=1, the head entry (TDATA/TKEEP/TLAST) is stable until the pop, except on reset.
- Outputs valid and busy are registered state decodes: valid = (state==DONE), busy = (state==LOAD).

Optional Feature:
- Macro: AXIS_SERIALIZER_DRAIN_WAIT_EN.
- Defined: valid = (state==DONE) & FIFO empty & no beat in flight. valid therefore asserts only after the TLAST beat handshake, which gives end-to-end completion for the controller.
- Undefined: valid = (state==DONE), i.e. asserted as soon as the last beat is queued, regardless of drain.

Test Plan:
- Basic pack, defaults (N=10, LANES=4), chars 0x01..0x0A, TREADY=1 -> beats 0x04030201/keep F/last 0, 0x08070605/F/0, 0x00000A09/3/1. valid=1 at edge t+3; TVALID first high after t+1.
- Backpressure, DEPTH=2, TREADY=0 for 10 cycles -> busy=1 and stalls after 2 beats, TVALID=1 with beat0 held stable. After TREADY=1, all 3 beats emerge in order, then valid=1.
- Abort: drop run after the first write -> state IDLE and busy=0 next cycle. Exactly one beat (keep F, last 0) drains; no TLAST. Rerun with new d yields a full 3-beat packet.
- Exact fit, LANES=5, N=10 -> 2 beats, both keep 0x1F, TLAST on the second; no zero-padded lanes.
- Reset mid-drain: ARESETN=0 for one edge while 2 beats are queued -> next cycle TVALID=0, TDATA/TKEEP/TLAST=0, valid=0, busy=0. The async reset path is not exercised (drive a reset pulse between edges; no effect).
- DRAIN_WAIT_EN defined, TREADY toggling 1/0 -> valid rises only the cycle after the TLAST handshake. Undefined -> valid rises at the last write edge.
